// File: rtl/apa102_pkg.sv
// Shared types and constants for the apa102 read arbiter.
package apa102_pkg;

    localparam int DATA_W       = 16;
    localparam int MAX_CHANNELS = 8;
    localparam int CH_IDX_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner selection over the eligible channel vector.
// Optional build macro APA102_ARB_PRIORITY0_EN: channel 0 wins whenever it is
// eligible; the rotating search then only ever lands on channels 1..N-1.
module rr_picker
    import apa102_pkg::*;
#(
    parameter int CHANNELS = 4
) (
    input  logic [CHANNELS-1:0] eligible,
    input  logic [CH_IDX_W-1:0] last_grant,
    output logic [CH_IDX_W-1:0] winner,
    output logic                valid
);

    localparam int IW1 = CH_IDX_W + 1;

    logic [MAX_CHANNELS-1:0] elig_pad;
    logic [IW1-1:0]          idx;

    assign elig_pad = MAX_CHANNELS'(eligible);

    // First eligible channel searching upward from last_grant+1, wrapping at CHANNELS.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
`ifdef APA102_ARB_PRIORITY0_EN
        if (elig_pad[0]) begin
            winner = '0;
            valid  = 1'b1;
        end
`endif
        for (int i = 1; i <= MAX_CHANNELS; i++) begin
            if (i <= CHANNELS) begin
                idx = {1'b0, last_grant} + IW1'(i);
                if (idx >= IW1'(CHANNELS)) begin
                    idx = idx - IW1'(CHANNELS);
                end
                if (!valid && elig_pad[idx[CH_IDX_W-1:0]]) begin
                    winner = idx[CH_IDX_W-1:0];
                    valid  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/apa102_read_arbiter.sv
// Shares one memory read port among CHANNELS apa102 output channels.
// One read in flight: IDLE (grant) -> ISSUE -> WAIT x READ_LATENCY -> DELIVER.
// Handshake: a channel holding ch_read_request high is eligible once its
// holdoff counter is zero; a granted read always completes and is signalled
// by a one-cycle ch_read_finished_strobe with ch_read_data valid that cycle.
// Optional build macro APA102_ARB_PRIORITY0_EN gives channel 0 fixed priority.
module apa102_read_arbiter
    import apa102_pkg::*;
#(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int CHANNELS          = 4,
    parameter int READ_LATENCY      = 1,
    parameter int HOLDOFF           = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [CHANNELS-1:0]                   ch_read_request,
    input  logic [CHANNELS*ADDRESS_BUS_WIDTH-1:0] ch_read_address,
    output logic [DATA_W-1:0]                     ch_read_data,
    output logic [CHANNELS-1:0]                   ch_read_finished_strobe,
    output logic [ADDRESS_BUS_WIDTH-1:0]          mem_address,
    output logic                                  mem_read_enable,
    input  logic [DATA_W-1:0]                     mem_read_data,
    output logic                                  busy
);

    arb_state_t              state, next_state;
    logic [CH_IDX_W-1:0]     winner, last_grant, pick_winner;
    logic                    pick_valid;
    logic [1:0]              wait_cnt;
    logic [1:0]              holdoff [CHANNELS];
    logic [CHANNELS-1:0]     eligible;
    logic [ADDRESS_BUS_WIDTH-1:0] addr_sel;

    // A channel competes only while requesting and out of holdoff.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            eligible[i] = ch_read_request[i] && (holdoff[i] == 2'd0);
        end
    end

    rr_picker #(.CHANNELS(CHANNELS)) u_picker (
        .eligible   (eligible),
        .last_grant (last_grant),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    // Address of the latched winner, sampled live during ISSUE.
    always_comb begin
        addr_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (winner == CH_IDX_W'(i)) begin
                addr_sel = ch_read_address[i*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH];
            end
        end
    end

    // Next-state logic for the single-outstanding-read sequence.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (pick_valid) next_state = ST_ISSUE;
            ST_ISSUE:   next_state = ST_WAIT;
            ST_WAIT:    if (wait_cnt == 2'(READ_LATENCY - 1)) next_state = ST_DELIVER;
            ST_DELIVER: next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Datapath: grant latch, read command, latency count, capture and strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            winner                  <= '0;
            last_grant              <= CH_IDX_W'(CHANNELS - 1);
            wait_cnt                <= '0;
            mem_address             <= '0;
            mem_read_enable         <= 1'b0;
            ch_read_data            <= '0;
            ch_read_finished_strobe <= '0;
        end else begin
            mem_read_enable         <= 1'b0;
            ch_read_finished_strobe <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) winner <= pick_winner;
                end
                ST_ISSUE: begin
                    mem_address     <= addr_sel;
                    mem_read_enable <= 1'b1;
                    wait_cnt        <= '0;
`ifdef APA102_ARB_PRIORITY0_EN
                    // Channel 0 grants leave the rotation pointer alone so the
                    // other channels keep cycling fairly among themselves.
                    if (winner != '0) last_grant <= winner;
`else
                    last_grant      <= winner;
`endif
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 2'd1;
                end
                ST_DELIVER: begin
                    // Memory word is valid in this cycle; it is captured and
                    // announced on the same edge so data and strobe align.
                    ch_read_data            <= mem_read_data;
                    ch_read_finished_strobe <= CHANNELS'(1) << winner;
                end
                default: ;
            endcase
        end
    end

    // Per-channel holdoff: loaded on delivery, otherwise counts down to zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (rst) begin
                holdoff[i] <= 2'd0;
            end else if (state == ST_DELIVER && winner == CH_IDX_W'(i)) begin
                holdoff[i] <= 2'(HOLDOFF);
            end else if (holdoff[i] != 2'd0) begin
                holdoff[i] <= holdoff[i] - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_apa102_read_arbiter.sv
// Directed bench for apa102_read_arbiter. Three instances share the request
// and address stimulus: d1 (latency 1, holdoff 2), d3 (latency 3, holdoff 2)
// and dh (latency 1, holdoff 1). Build macro APA102_ARB_PRIORITY0_EN selects
// the fixed-priority expectations for the dh scenario.
module tb_apa102_read_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] addr_bus;

    logic [15:0] d1_data, d3_data, dh_data;
    logic [3:0]  d1_strobe, d3_strobe, dh_strobe;
    logic [15:0] d1_addr, d3_addr, dh_addr;
    logic        d1_en, d3_en, dh_en;
    logic        d1_busy, d3_busy, dh_busy;
    logic [15:0] md1, md3, mdh, p31, p32;

    int cyc = 0;
    int passed = 0;
    int total = 0;
    int overlap = 0;

    apa102_read_arbiter #(.ADDRESS_BUS_WIDTH(16), .CHANNELS(4), .READ_LATENCY(1), .HOLDOFF(2)) d1 (
        .clk(clk), .rst(rst), .ch_read_request(req), .ch_read_address(addr_bus),
        .ch_read_data(d1_data), .ch_read_finished_strobe(d1_strobe),
        .mem_address(d1_addr), .mem_read_enable(d1_en), .mem_read_data(md1), .busy(d1_busy));

    apa102_read_arbiter #(.ADDRESS_BUS_WIDTH(16), .CHANNELS(4), .READ_LATENCY(3), .HOLDOFF(2)) d3 (
        .clk(clk), .rst(rst), .ch_read_request(req), .ch_read_address(addr_bus),
        .ch_read_data(d3_data), .ch_read_finished_strobe(d3_strobe),
        .mem_address(d3_addr), .mem_read_enable(d3_en), .mem_read_data(md3), .busy(d3_busy));

    apa102_read_arbiter #(.ADDRESS_BUS_WIDTH(16), .CHANNELS(4), .READ_LATENCY(1), .HOLDOFF(1)) dh (
        .clk(clk), .rst(rst), .ch_read_request(req), .ch_read_address(addr_bus),
        .ch_read_data(dh_data), .ch_read_finished_strobe(dh_strobe),
        .mem_address(dh_addr), .mem_read_enable(dh_en), .mem_read_data(mdh), .busy(dh_busy));

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory content: 0x0010 holds 0xBEEF, every other word is address ^ 0x5A00.
    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A00);
    endfunction

    // Memory models; data is driven only in the cycle it is valid.
    always @(posedge clk) begin
        md1 <= d1_en ? mem_f(d1_addr) : 16'h0000;
        mdh <= dh_en ? mem_f(dh_addr) : 16'h0000;
        p31 <= d3_en ? mem_f(d3_addr) : 16'h0000;
        p32 <= p31;
        md3 <= p32;
    end

    // Read command and delivery strobe must never coincide.
    always @(negedge clk) begin
        if ((d1_en && |d1_strobe) || (d3_en && |d3_strobe) || (dh_en && |dh_strobe))
            overlap++;
    end

    task automatic do_reset();
        rst = 1'b1;
        req = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_rr_addresses();
        for (int n = 0; n < 4; n++) addr_bus[n*16 +: 16] = 16'h0100 + 16'(n);
    endtask

    // Wait (bounded) for the next strobe of instance sel: 1=d1, 2=dh, 3=d3.
    task automatic wait_strobe(input int sel, output int c, output logic [3:0] s,
                               output logic [15:0] d);
        logic [3:0]  cs;
        logic [15:0] cd;
        c = -1;
        s = 4'h0;
        d = 16'h0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cs = (sel == 1) ? d1_strobe : (sel == 2) ? dh_strobe : d3_strobe;
            cd = (sel == 1) ? d1_data   : (sel == 2) ? dh_data   : d3_data;
            if (c < 0 && cs != 4'h0) begin
                c = cyc;
                s = cs;
                d = cd;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'hF;
        addr_bus = 64'h0010_0010_0010_0010;
        repeat (3) @(negedge clk);
        total++; if (d1_busy !== 1'b0) $display("FAIL reset_busy got=%0h exp=0", d1_busy); else passed++;
        total++; if (d1_en !== 1'b0) $display("FAIL reset_en got=%0h exp=0", d1_en); else passed++;
        total++; if (d1_strobe !== 4'h0) $display("FAIL reset_strobe got=%0h exp=0", d1_strobe); else passed++;
        total++; if (d1_data !== 16'h0) $display("FAIL reset_data got=%0h exp=0", d1_data); else passed++;
        total++; if (d1_addr !== 16'h0) $display("FAIL reset_addr got=%0h exp=0", d1_addr); else passed++;
        rst = 1'b0;
        req = 4'h0;
    endtask

    task automatic test_single_read();
        int c_s, c, ce;
        logic [3:0]  s;
        logic [15:0] d;
        do_reset();
        addr_bus[15:0] = 16'h0010;
        req = 4'h1;
        @(negedge clk);
        total++; if (d1_busy !== 1'b1) $display("FAIL single_busy got=%0h exp=1", d1_busy); else passed++;
        total++; if (d1_en !== 1'b0) $display("FAIL single_en_early got=%0h exp=0", d1_en); else passed++;
        @(negedge clk);
        total++; if (d1_en !== 1'b1) $display("FAIL single_en got=%0h exp=1", d1_en); else passed++;
        total++; if (d1_addr !== 16'h0010) $display("FAIL single_addr got=%0h exp=0010", d1_addr); else passed++;
        @(negedge clk);
        total++; if (d1_strobe !== 4'h0) $display("FAIL single_strobe_early got=%0h exp=0", d1_strobe); else passed++;
        @(negedge clk);
        c_s = cyc;
        total++; if (d1_strobe !== 4'h1) $display("FAIL single_strobe got=%0h exp=1", d1_strobe); else passed++;
        total++; if (d1_data !== 16'hBEEF) $display("FAIL single_data got=%0h exp=beef", d1_data); else passed++;
        // Holdoff 2: the next read command comes 4 cycles after the strobe.
        ce = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ce < 0 && d1_en) ce = cyc;
            if (ce >= 0) break;
        end
        total++; if (ce - c_s !== 4) $display("FAIL holdoff_issue_gap got=%0d exp=4", ce - c_s); else passed++;
        wait_strobe(1, c, s, d);
        total++; if (c - c_s !== 6) $display("FAIL holdoff_strobe_gap got=%0d exp=6", c - c_s); else passed++;
        req = 4'h0;
        repeat (8) @(negedge clk);
        total++; if (d1_data !== 16'hBEEF) $display("FAIL data_hold got=%0h exp=beef", d1_data); else passed++;
        total++; if (d1_busy !== 1'b0) $display("FAIL idle_busy got=%0h exp=0", d1_busy); else passed++;
    endtask

    task automatic test_round_robin(input int sel, input int spacing);
        logic [3:0]  exp_s [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        logic [15:0] exp_d [5] = '{16'h5B00, 16'h5B01, 16'h5B02, 16'h5B03, 16'h5B00};
        int prev, c;
        logic [3:0]  s;
        logic [15:0] d;
        do_reset();
        set_rr_addresses();
        req = 4'hF;
        prev = -1;
        for (int n = 0; n < 5; n++) begin
            wait_strobe(sel, c, s, d);
            total++; if (s !== exp_s[n]) $display("FAIL rr%0d_grant%0d got=%0h exp=%0h", sel, n, s, exp_s[n]); else passed++;
            total++; if (d !== exp_d[n]) $display("FAIL rr%0d_data%0d got=%0h exp=%0h", sel, n, d, exp_d[n]); else passed++;
            if (n > 0) begin
                total++; if (c - prev !== spacing) $display("FAIL rr%0d_spacing%0d got=%0d exp=%0d", sel, n, c - prev, spacing); else passed++;
            end
            prev = c;
        end
        req = 4'h0;
    endtask

    task automatic test_reset_in_wait();
        int c;
        logic [3:0]  s;
        logic [15:0] d;
        do_reset();
        set_rr_addresses();
        addr_bus[15:0] = 16'h0010;
        req = 4'h1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (d1_busy !== 1'b0) $display("FAIL abort_busy got=%0h exp=0", d1_busy); else passed++;
        total++; if (d1_strobe !== 4'h0) $display("FAIL abort_strobe got=%0h exp=0", d1_strobe); else passed++;
        rst = 1'b0;
        req = 4'hF;
        @(negedge clk);
        total++; if (d1_strobe !== 4'h0) $display("FAIL abort_late_strobe got=%0h exp=0", d1_strobe); else passed++;
        wait_strobe(1, c, s, d);
        total++; if (s !== 4'h1) $display("FAIL abort_first_grant got=%0h exp=1", s); else passed++;
        req = 4'h0;
    endtask

    task automatic test_drop_after_grant();
        int c;
        logic [3:0]  s;
        logic [15:0] d;
        do_reset();
        addr_bus[47:32] = 16'h0222;
        req = 4'h4;
        @(negedge clk);
        req = 4'h0;
        wait_strobe(1, c, s, d);
        total++; if (s !== 4'h4) $display("FAIL drop_strobe got=%0h exp=4", s); else passed++;
        total++; if (d !== 16'h5822) $display("FAIL drop_data got=%0h exp=5822", d); else passed++;
        wait_strobe(1, c, s, d);
        total++; if (s !== 4'h0) $display("FAIL drop_extra_strobe got=%0h exp=0", s); else passed++;
    endtask

    task automatic test_priority();
`ifdef APA102_ARB_PRIORITY0_EN
        logic [3:0] exp_s [4] = '{4'h1, 4'h2, 4'h1, 4'h4};
`else
        logic [3:0] exp_s [4] = '{4'h1, 4'h2, 4'h4, 4'h1};
`endif
        int c;
        logic [3:0]  s;
        logic [15:0] d;
        do_reset();
        set_rr_addresses();
        req = 4'h7;
        for (int n = 0; n < 4; n++) begin
            wait_strobe(2, c, s, d);
            total++; if (s !== exp_s[n]) $display("FAIL prio_grant%0d got=%0h exp=%0h", n, s, exp_s[n]); else passed++;
        end
        req = 4'h0;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'h0;
        addr_bus = '0;
        test_reset();
        test_single_read();
        test_round_robin(1, 4);
        test_round_robin(3, 6);
        test_reset_in_wait();
        test_drop_after_grant();
        test_priority();
        total++; if (overlap !== 0) $display("FAIL en_strobe_overlap got=%0d exp=0", overlap); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/apa102_read_arbiter.md
APA102_READ_ARBITER -- requirements
Module: apa102_read_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_BUS_WIDTH, default 16: width of every address bus.
REQ-002 SHALL have parameter CHANNELS, default 4: number of apa102 output channels sharing one memory read port (legal 2..8).
REQ-003 SHALL have parameter READ_LATENCY, default 1: cycles from mem_read_enable to valid mem_read_data (legal 1..3).
REQ-004 SHALL have parameter HOLDOFF, default 2: cycles a channel is ineligible after its strobe (legal 1..3).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  system clock; all logic on posedge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 ch_read_request  in  CHANNELS  per-channel level request (fifo not full).
REQ-009 ch_read_address  in  CHANNELS*ADDRESS_BUS_WIDTH  flattened; channel n at bits [n*AW +: AW].
REQ-010 ch_read_data  out  16  broadcast data word, registered.
REQ-011 ch_read_finished_strobe  out  CHANNELS  one-hot, one-cycle delivery strobe.
REQ-012 mem_address  out  ADDRESS_BUS_WIDTH  memory read address, registered.
REQ-013 mem_read_enable  out  1  one-cycle read command.
REQ-014 mem_read_data  in  16  memory data, valid READ_LATENCY cycles after mem_read_enable.
REQ-015 busy  out  1  high in every state other than IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DELIVER -> IDLE, one transaction outstanding at a time.
REQ-017 IDLE: if any channel is eligible (request high, holdoff counter zero), SHALL latch the round-robin winner, searching upward from last_grant+1 modulo CHANNELS, and go to ISSUE; otherwise stay in IDLE.
REQ-018 ISSUE: SHALL drive mem_address = winner's ch_read_address sampled this cycle, assert mem_read_enable for exactly this cycle, and update last_grant to the winner.
REQ-019 WAIT: SHALL count READ_LATENCY cycles, then capture mem_read_data into ch_read_data.
REQ-020 DELIVER: SHALL assert ch_read_finished_strobe[winner] for exactly one cycle, load that channel's holdoff counter with HOLDOFF, and return to IDLE.
REQ-021 Transaction latency, grant-latch edge to strobe: READ_LATENCY+2 cycles; peak throughput one word per READ_LATENCY+3 cycles.
REQ-022 ch_read_data SHALL hold its value until the next capture.
REQ-023 A granted transaction SHALL complete and strobe even if its request deasserts after the grant.
REQ-024 A request asserted in IDLE SHALL be considered in the same cycle; no channel is starved: max wait is CHANNELS transactions.
REQ-025 Holdoff counters SHALL decrement to zero independently in every state.
REQ-026 mem_read_enable and ch_read_finished_strobe SHALL never be high in the same cycle.

Reset
REQ-027 On rst: state=IDLE, last_grant=CHANNELS-1 (channel 0 wins first), holdoff counters=0, ch_read_data=0, strobes=0, mem_address=0, mem_read_enable=0, busy=0.
REQ-028 Reset mid-transaction SHALL abort it; no strobe is emitted for the aborted read.

Configuration
REQ-029 Macro APA102_ARB_PRIORITY0_EN: when defined, channel 0 SHALL win whenever eligible, and round-robin applies only among channels 1..CHANNELS-1; when undefined, pure round-robin over all channels.

Structure
REQ-030 Package apa102_pkg SHALL hold the FSM state type, data width constant (16) and the CHANNELS upper bound (8).
REQ-031 Sub-module rr_picker SHALL compute the winner index and valid flag from the eligible vector and last_grant (and the priority-0 option); everything else stays in apa102_read_arbiter.

Verification
REQ-032 Ch0 only requests, address 0x0010, READ_LATENCY=1, memory returns 0xBEEF -> mem_read_enable with mem_address=0x0010 one cycle after grant; strobe[0] 3 cycles after grant with ch_read_data=0xBEEF.
REQ-033 All 4 channels request continuously -> grants ch0,ch1,ch2,ch3,ch0; spacing 4 cycles at READ_LATENCY=1, 6 cycles at READ_LATENCY=3.
REQ-034 Single channel requests continuously, HOLDOFF=2 -> no grant within 2 cycles after each strobe; no read issued for that channel while its holdoff is nonzero.
REQ-035 rst asserted in WAIT -> next cycle busy=0, no strobe; post-reset first grant goes to ch0.
REQ-036 Ch2 request drops the cycle after its grant -> strobe[2] still delivered, ch_read_data equals memory word.
REQ-037 With APA102_ARB_PRIORITY0_EN, ch0 and ch1 requesting continuously, HOLDOFF=1 -> ch0 granted whenever eligible; ch1 granted only while ch0 is in holdoff.
